// File: rtl/spi_flash_cmd_ctrl.sv
// SPI flash command sequencer: two requesters share one mode-0 flash bus via
// round-robin grant; opcode, optional 24-bit address, then len read bytes.
module spi_flash_cmd_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_opcode,
    input  logic        req0_use_addr,
    input  logic [23:0] req0_addr,
    input  logic [7:0]  req0_len,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_opcode,
    input  logic        req1_use_addr,
    input  logic [23:0] req1_addr,
    input  logic [7:0]  req1_len,
    output logic        req1_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_src,
    output logic        done,
    output logic        done_src,
    output logic        cs,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);
    // state | meaning
    // IDLE  | bus released; arbitrate, then one cycle with the ready strobe
    // SETUP | cs low, sck low, opcode[7] on mosi
    // CMD   | shifting the 8 opcode bits
    // ADDR  | shifting the 24 address bits
    // DATA  | clocking len bytes in from miso, mosi held low
    // HOLD  | sck low before cs release
    // GAP   | cs high recovery before the next arbitration
    typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DATA, HOLD, GAP} state_t;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic          phase, phase_nxt;
    logic [11:0]   bit_cnt, bit_nxt;
    logic [31:0]   tx_sr, tx_nxt;
    logic [7:0]    rx_sr, rx_nxt;
    logic          use_addr, use_addr_nxt;
    logic [7:0]    len, len_nxt;
    logic          grant, grant_nxt;
    logic          last_grant, last_grant_nxt;
    logic          pend, pend_nxt;
    logic          ready0_nxt, ready1_nxt;
    logic [7:0]    rd_data_nxt;
    logic          rd_valid_nxt, rd_src_nxt, done_nxt, done_src_nxt;
    logic          cs_nxt, sck_nxt, mosi_nxt;
    logic          half_end, pick;

    always_comb begin
        state_nxt      = state;
        div_nxt        = div_cnt;
        phase_nxt      = phase;
        bit_nxt        = bit_cnt;
        tx_nxt         = tx_sr;
        rx_nxt         = rx_sr;
        use_addr_nxt   = use_addr;
        len_nxt        = len;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        pend_nxt       = 1'b0;
        ready0_nxt     = 1'b0;
        ready1_nxt     = 1'b0;
        rd_data_nxt    = rd_data;
        rd_valid_nxt   = 1'b0;
        rd_src_nxt     = rd_src;
        done_nxt       = 1'b0;
        done_src_nxt   = done_src;
        pick           = 1'b0;
        half_end       = (div_cnt == DIV_LAST);

        case (state)
            IDLE: begin
                // pend marks the ready cycle so a still-held valid is not granted twice
                if (pend) begin
                    state_nxt = SETUP;
                    div_nxt   = '0;
                    phase_nxt = 1'b0;
                end else if (req0_valid || req1_valid) begin
                    pick           = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    pend_nxt       = 1'b1;
                    ready0_nxt     = ~pick;
                    ready1_nxt     = pick;
                    tx_nxt         = pick ? {req1_opcode, req1_addr} : {req0_opcode, req0_addr};
                    use_addr_nxt   = pick ? req1_use_addr : req0_use_addr;
                    len_nxt        = pick ? req1_len : req0_len;
                end
            end
            SETUP: begin
                if (half_end) begin
                    state_nxt = CMD;
                    div_nxt   = '0;
                    bit_nxt   = 12'd8;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            CMD, ADDR, DATA: begin
                if (!half_end) begin
                    div_nxt = div_cnt + 1'b1;
                end else begin
                    div_nxt   = '0;
                    phase_nxt = ~phase;
                    if (phase) begin
                        tx_nxt  = {tx_sr[30:0], 1'b0};
                        bit_nxt = bit_cnt - 12'd1;
                        if (state == DATA) begin
                            rx_nxt = {rx_sr[6:0], miso};
                            // remaining count is a multiple of 8 plus one on each byte's last bit
                            if (bit_cnt[2:0] == 3'd1) begin
                                rd_data_nxt  = {rx_sr[6:0], miso};
                                rd_valid_nxt = 1'b1;
                                rd_src_nxt   = grant;
                            end
                        end
                        if (bit_cnt == 12'd1) begin
                            if (state == CMD && use_addr) begin
                                state_nxt = ADDR;
                                bit_nxt   = 12'd24;
                            end else if (state != DATA && len != 8'd0) begin
                                state_nxt = DATA;
                                bit_nxt   = {1'b0, len, 3'b000};
                            end else begin
                                state_nxt = HOLD;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    state_nxt    = GAP;
                    div_nxt      = '0;
                    phase_nxt    = 1'b0;
                    done_nxt     = 1'b1;
                    done_src_nxt = grant;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (half_end) begin
                    div_nxt   = '0;
                    phase_nxt = ~phase;
                    if (phase) state_nxt = IDLE;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        cs_nxt   = !(state_nxt inside {SETUP, CMD, ADDR, DATA, HOLD});
        sck_nxt  = phase_nxt && (state_nxt inside {CMD, ADDR, DATA});
        mosi_nxt = (state_nxt inside {SETUP, CMD, ADDR}) ? tx_nxt[31] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            use_addr   <= 1'b0;
            len        <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            pend       <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_src     <= 1'b0;
            done       <= 1'b0;
            done_src   <= 1'b0;
            cs         <= 1'b1;
            sck        <= 1'b0;
            mosi       <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            phase      <= phase_nxt;
            bit_cnt    <= bit_nxt;
            tx_sr      <= tx_nxt;
            rx_sr      <= rx_nxt;
            use_addr   <= use_addr_nxt;
            len        <= len_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            pend       <= pend_nxt;
            req0_ready <= ready0_nxt;
            req1_ready <= ready1_nxt;
            rd_data    <= rd_data_nxt;
            rd_valid   <= rd_valid_nxt;
            rd_src     <= rd_src_nxt;
            done       <= done_nxt;
            done_src   <= done_src_nxt;
            cs         <= cs_nxt;
            sck        <= sck_nxt;
            mosi       <= mosi_nxt;
        end
    end
endmodule

// File: tb/tb_spi_flash_cmd_ctrl.sv
// Bench for spi_flash_cmd_ctrl: a CLK_DIV=2 unit and a CLK_DIV=1 unit, one observed at a time,
// checked against a transaction-level model of the expected bus and read stream.
module tb_spi_flash_cmd_ctrl;
    typedef struct packed {
        logic        src;
        logic [7:0]  op;
        logic        ua;
        logic [23:0] addr;
        logic [7:0]  len;
        logic [31:0] resp;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    int          dv = 2;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [7:0]  op0 = '0;
    logic [7:0]  op1 = '0;
    logic [7:0]  len0 = '0;
    logic [7:0]  len1 = '0;
    logic        ua0 = 1'b0;
    logic        ua1 = 1'b0;
    logic [23:0] ad0 = '0;
    logic [23:0] ad1 = '0;
    logic        miso = 1'b1;

    logic       a_r0, a_r1, a_rv, a_rs, a_dn, a_ds, a_cs, a_sck, a_mosi;
    logic       b_r0, b_r1, b_rv, b_rs, b_dn, b_ds, b_cs, b_sck, b_mosi;
    logic [7:0] a_rd, b_rd;
    logic       r0, r1, rd_valid, rd_src, done, done_src, cs, sck, mosi;
    logic [7:0] rd_data;

    always #5 clk = ~clk;

    spi_flash_cmd_ctrl #(.CLK_DIV(2)) u_div2 (
        .clk(clk), .rst(rst),
        .req0_valid(v0 & ~sel), .req0_opcode(op0), .req0_use_addr(ua0), .req0_addr(ad0),
        .req0_len(len0), .req0_ready(a_r0),
        .req1_valid(v1 & ~sel), .req1_opcode(op1), .req1_use_addr(ua1), .req1_addr(ad1),
        .req1_len(len1), .req1_ready(a_r1),
        .rd_data(a_rd), .rd_valid(a_rv), .rd_src(a_rs), .done(a_dn), .done_src(a_ds),
        .cs(a_cs), .sck(a_sck), .mosi(a_mosi), .miso(miso)
    );

    spi_flash_cmd_ctrl #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0 & sel), .req0_opcode(op0), .req0_use_addr(ua0), .req0_addr(ad0),
        .req0_len(len0), .req0_ready(b_r0),
        .req1_valid(v1 & sel), .req1_opcode(op1), .req1_use_addr(ua1), .req1_addr(ad1),
        .req1_len(len1), .req1_ready(b_r1),
        .rd_data(b_rd), .rd_valid(b_rv), .rd_src(b_rs), .done(b_dn), .done_src(b_ds),
        .cs(b_cs), .sck(b_sck), .mosi(b_mosi), .miso(miso)
    );

    assign r0       = sel ? b_r0   : a_r0;
    assign r1       = sel ? b_r1   : a_r1;
    assign rd_data  = sel ? b_rd   : a_rd;
    assign rd_valid = sel ? b_rv   : a_rv;
    assign rd_src   = sel ? b_rs   : a_rs;
    assign done     = sel ? b_dn   : a_dn;
    assign done_src = sel ? b_ds   : a_ds;
    assign cs       = sel ? b_cs   : a_cs;
    assign sck      = sel ? b_sck  : a_sck;
    assign mosi     = sel ? b_mosi : a_mosi;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---- transaction-level model ----
    function automatic txn_t mk(logic s, logic [7:0] op, logic ua, logic [23:0] a,
                                logic [7:0] n, logic [31:0] resp);
        txn_t t;
        t.src = s; t.op = op; t.ua = ua; t.addr = a; t.len = n; t.resp = resp;
        return t;
    endfunction

    function automatic int cmd_bits(txn_t t);
        return 8 + (t.ua ? 24 : 0);
    endfunction

    function automatic int n_bits(txn_t t);
        return cmd_bits(t) + 8 * int'(t.len);
    endfunction

    function automatic int cs_low(txn_t t, int d);
        return d * (2 + 2 * n_bits(t));
    endfunction

    function automatic logic mosi_bit(txn_t t, int i);
        logic [7:0]  o;
        logic [23:0] a;
        o = t.op;
        a = t.addr;
        if (i < 8) return o[7 - i];
        if (t.ua && i < 32) return a[31 - i];
        return 1'b0;
    endfunction

    function automatic logic miso_bit(txn_t t, int i);
        logic [31:0] r;
        r = t.resp;
        if (i > 31) return 1'b1;
        return r[31 - i];
    endfunction

    function automatic logic [7:0] resp_byte(txn_t t, int k);
        logic [31:0] s;
        if (k > 3) return 8'h00;
        s = t.resp >> (24 - 8 * k);
        return s[7:0];
    endfunction

    txn_t expq[$];
    txn_t cur;

    // ---- bus observer / compare process ----
    int          lowcnt = 0, rises = 0, hicnt = 0, gap = 0, rdn = 0;
    int          last_low = 0, last_rises = 0;
    logic [23:0] last_rd = '0;
    logic [3:0]  glog = '0;
    bit          had_txn = 0, prev_sck = 0, prev_cs = 1, prev_mosi = 0;

    always @(negedge clk) begin
        if (rst) begin
            lowcnt = 0; rises = 0; hicnt = 0; gap = 0; rdn = 0; had_txn = 0;
            prev_sck = 0; prev_cs = 1; prev_mosi = 0; miso = 1'b1;
        end else begin
            chk("ready_exclusive", !(r0 && r1), {r0, r1}, 0);
            if (r0 || r1) begin
                glog = {glog[2:0], r1};
                if (expq.size() == 0) chk("ready_unexpected", 1'b0, 1, 0);
                else chk("grant_src", r1 == expq[0].src, r1, expq[0].src);
            end
            if (!cs) begin
                if (prev_cs) begin
                    if (had_txn) chk("cs_gap_min", gap >= 2 * dv + 1, gap, 2 * dv + 1);
                    lowcnt = 0; rises = 0; rdn = 0; last_rd = '0;
                end
                lowcnt++;
            end else begin
                chk("sck_idle_while_cs_high", sck == 1'b0, sck, 0);
                if (!prev_cs) gap = 0;
                gap++;
            end
            if (sck && !prev_sck) begin
                if (expq.size() != 0)
                    chk("mosi_bit", mosi == mosi_bit(expq[0], rises), mosi, mosi_bit(expq[0], rises));
                rises++;
                hicnt = 0;
            end
            if (sck) begin
                if (prev_sck) chk("mosi_stable_sck_high", mosi == prev_mosi, mosi, prev_mosi);
                hicnt++;
            end else if (prev_sck) begin
                chk("sck_high_len", hicnt == dv, hicnt, dv);
            end
            if (rd_valid) begin
                if (expq.size() == 0) begin
                    chk("rd_unexpected", 1'b0, rd_data, 0);
                end else begin
                    chk("rd_data", rd_data == resp_byte(expq[0], rdn), rd_data, resp_byte(expq[0], rdn));
                    chk("rd_src", rd_src == expq[0].src, rd_src, expq[0].src);
                    chk("rd_count", rdn < int'(expq[0].len), rdn + 1, expq[0].len);
                end
                last_rd = {last_rd[15:0], rd_data};
                rdn++;
            end
            if (done) begin
                if (expq.size() == 0) begin
                    chk("done_unexpected", 1'b0, 1, 0);
                end else begin
                    cur = expq.pop_front();
                    chk("done_src", done_src == cur.src, done_src, cur.src);
                    chk("done_with_cs_high", cs == 1'b1, cs, 1);
                    chk("cs_low_cycles", lowcnt == cs_low(cur, dv), lowcnt, cs_low(cur, dv));
                    chk("sck_rises", rises == n_bits(cur), rises, n_bits(cur));
                    chk("rd_bytes", rdn == int'(cur.len), rdn, cur.len);
                    last_low = lowcnt;
                    last_rises = rises;
                    had_txn = 1;
                end
            end
            // flash side: present the next data bit while sck is low
            if (!sck)
                miso = (!cs && expq.size() != 0 && rises >= cmd_bits(expq[0]))
                       ? miso_bit(expq[0], rises - cmd_bits(expq[0])) : 1'b1;
            prev_sck = sck; prev_cs = cs; prev_mosi = mosi;
        end
    end

    // ---- stimulus helpers ----
    task automatic set_fields(input txn_t t);
        if (t.src) begin op1 = t.op; ua1 = t.ua; ad1 = t.addr; len1 = t.len; end
        else begin op0 = t.op; ua0 = t.ua; ad0 = t.addr; len0 = t.len; end
    endtask

    task automatic issue(input txn_t t);
        int seen;
        expq.push_back(t);
        set_fields(t);
        if (t.src) v1 = 1'b1; else v0 = 1'b1;
        seen = 0;
        for (int c = 0; c < 3000 && seen == 0; c++) begin
            @(negedge clk);
            if (t.src ? r1 : r0) seen = 1;
        end
        chk("issue_ready", seen == 1, seen, 1);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic run_both(input int n);
        v0 = 1'b1;
        v1 = 1'b1;
        fork
            begin
                int got = 0;
                for (int c = 0; c < 4000 && got < n; c++) begin
                    @(negedge clk);
                    if (r0) begin got++; if (got == n) v0 = 1'b0; end
                end
                chk("req0_accepts", got == n, got, n);
                v0 = 1'b0;
            end
            begin
                int got = 0;
                for (int c = 0; c < 4000 && got < n; c++) begin
                    @(negedge clk);
                    if (r1) begin got++; if (got == n) v1 = 1'b0; end
                end
                chk("req1_accepts", got == n, got, n);
                v1 = 1'b0;
            end
        join
    endtask

    task automatic wait_empty(input int budget);
        for (int c = 0; c < budget && expq.size() != 0; c++) @(negedge clk);
        chk("txn_complete", expq.size() == 0, expq.size(), 0);
        expq.delete();
        repeat (2) @(negedge clk);
    endtask

    txn_t jedec, rdcmd, wren;

    initial begin
        jedec = mk(1'b0, 8'h9F, 1'b0, 24'h000000, 8'd3, 32'hEF401600);
        rdcmd = mk(1'b1, 8'h03, 1'b1, 24'h100000, 8'd2, 32'hA53C0000);
        wren  = mk(1'b0, 8'h06, 1'b0, 24'h000000, 8'd0, 32'h00000000);

        // model pins
        chk("model_cs_jedec", cs_low(jedec, 2) == 132, cs_low(jedec, 2), 132);
        chk("model_cs_read", cs_low(rdcmd, 2) == 196, cs_low(rdcmd, 2), 196);
        chk("model_cs_wren", cs_low(wren, 2) == 36, cs_low(wren, 2), 36);
        chk("model_cs_jedec_div1", cs_low(jedec, 1) == 66, cs_low(jedec, 1), 66);

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_cs", cs == 1'b1, cs, 1);
        chk("rst_sck", sck == 1'b0, sck, 0);
        chk("rst_mosi", mosi == 1'b0, mosi, 0);
        chk("rst_ready", {r0, r1} == 2'b00, {r0, r1}, 0);
        chk("rst_rd_valid", rd_valid == 1'b0, rd_valid, 0);
        chk("rst_rd_data", rd_data == 8'h00, rd_data, 0);
        chk("rst_done", {done, done_src, rd_src} == 3'b000, {done, done_src, rd_src}, 0);

        // arbitration with JEDEC ID and data read held valid from the first cycle after reset
        expq.push_back(jedec);
        expq.push_back(rdcmd);
        expq.push_back(jedec);
        expq.push_back(rdcmd);
        set_fields(jedec);
        set_fields(rdcmd);
        rst = 1'b0;
        run_both(2);
        wait_empty(3000);
        chk("grant_order", glog == 4'b0101, glog, 4'b0101);
        chk("read_cs_low", last_low == 196, last_low, 196);
        chk("read_bytes", last_rd == 24'h00A53C, last_rd, 24'h00A53C);

        // zero-length command
        issue(wren);
        wait_empty(1000);
        chk("wren_cs_low", last_low == 36, last_low, 36);
        chk("wren_sck_rises", last_rises == 8, last_rises, 8);

        // reset during the address phase of a read
        issue(rdcmd);
        for (int c = 0; c < 500 && !(rises >= 12 && !cs); c++) @(negedge clk);
        chk("reached_addr_phase", rises >= 12, rises, 12);
        rst = 1'b1;
        expq.delete();
        @(negedge clk);
        chk("abort_cs", cs == 1'b1, cs, 1);
        chk("abort_sck", sck == 1'b0, sck, 0);
        chk("abort_no_done", done == 1'b0, done, 0);
        chk("abort_no_rd", rd_valid == 1'b0, rd_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        expq.push_back(jedec);
        expq.push_back(rdcmd);
        set_fields(jedec);
        set_fields(rdcmd);
        run_both(1);
        wait_empty(2000);
        chk("post_reset_order", glog[1:0] == 2'b01, glog[1:0], 2'b01);

        // fastest divider
        rst = 1'b1;
        sel = 1'b1;
        dv = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(jedec);
        wait_empty(1000);
        chk("div1_cs_low", last_low == 66, last_low, 66);
        chk("div1_data", last_rd == 24'hEF4016, last_rd, 24'hEF4016);
        chk("div1_sck_rises", last_rises == 32, last_rises, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
